// File: rtl/if_stage_pkg.sv
// Shared CPU definitions for the fetch stage: reset/step defaults, NOP encoding,
// IF FSM state encoding and the saturating-increment helper.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEF  = 32'h0000_0004;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] CNT_MAX      = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } if_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == CNT_MAX) ? value : (value + 32'd1);
    endfunction

endpackage

// File: rtl/if_perf_counter.sv
// Saturating 32-bit event counter with enable. The counter flop exists only when
// IF_STAGE_PERF_CNT_EN is defined; otherwise cnt_o is tied to zero.
module if_perf_counter
    import if_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    output logic [31:0] cnt_o
);

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Next count: saturating increment on each enabled cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= 32'h0000_0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`else
    logic unused_s;
    assign unused_s = ^{clk_i, rst_n_i, en_i};
    assign cnt_o    = 32'h0000_0000;
`endif

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and IDLE/RUN FSM.
// Stall/flush counters are present only when IF_STAGE_PERF_CNT_EN is defined.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    if_state_e   state_q;
    if_state_e   state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] ifid_pc_q;
    logic [31:0] ifid_pc_d;
    logic [31:0] ifid_instr_q;
    logic [31:0] ifid_instr_d;
    logic        ifid_valid_q;
    logic        ifid_valid_d;
    logic [31:0] pc_next_s;
    logic        stall_evt_s;
    logic        flush_evt_s;

    assign pc_next_s = pc_q + PC_STEP;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start_i alone decides run versus idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath control: flush has priority over stall; idle ignores both.
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        case (state_q)
            ST_IDLE: begin
                ifid_pc_d    = 32'h0000_0000;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
            ST_RUN: begin
                if (flush_i) begin
                    pc_d         = branch_target_i;
                    ifid_pc_d    = 32'h0000_0000;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else begin
                    pc_d         = pc_next_s;
                    ifid_pc_d    = pc_next_s;
                    ifid_instr_d = imem_data_i;
                    ifid_valid_d = 1'b1;
                end
            end
            default: begin
                pc_d         = RESET_PC;
                ifid_pc_d    = 32'h0000_0000;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
        endcase
    end

    // PC and IF/ID registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_instr_q <= 32'h0000_0000;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign stall_evt_s = (state_q == ST_RUN) && stall_i && !flush_i;
    assign flush_evt_s = (state_q == ST_RUN) && flush_i;

    if_perf_counter u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (stall_evt_s),
        .cnt_o   (stall_cnt_o)
    );

    if_perf_counter u_flush_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (flush_evt_s),
        .cnt_o   (flush_cnt_o)
    );

    assign imem_addr_o  = pc_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_valid_o = ifid_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; instruction memory returns addr/4 + 1.
module tb_if_stage;

    logic        clk_s;
    logic        rst_n_s;
    logic        start_s;
    logic        stall_s;
    logic        flush_s;
    logic [31:0] target_s;
    logic [31:0] imem_addr_s;
    logic [31:0] imem_data_s;
    logic [31:0] ifid_pc_s;
    logic [31:0] ifid_instr_s;
    logic        ifid_valid_s;
    logic [31:0] stall_cnt_s;
    logic [31:0] flush_cnt_s;

    int errors_r = 0;
    int checks_r = 0;

`ifdef IF_STAGE_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    if_stage dut (
        .clk_i           (clk_s),
        .rst_n_i         (rst_n_s),
        .start_i         (start_s),
        .stall_i         (stall_s),
        .flush_i         (flush_s),
        .branch_target_i (target_s),
        .imem_addr_o     (imem_addr_s),
        .imem_data_i     (imem_data_s),
        .ifid_pc_o       (ifid_pc_s),
        .ifid_instr_o    (ifid_instr_s),
        .ifid_valid_o    (ifid_valid_s),
        .stall_cnt_o     (stall_cnt_s),
        .flush_cnt_o     (flush_cnt_s)
    );

    assign imem_data_s = (imem_addr_s >> 2) + 32'd1;

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] n);
        return PERF_EN ? n : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    initial begin
        rst_n_s  = 1'b0;
        start_s  = 1'b0;
        stall_s  = 1'b0;
        flush_s  = 1'b0;
        target_s = 32'h0;
        #2;
        chk("rst_addr",  imem_addr_s, 32'h0);
        chk("rst_pc",    ifid_pc_s, 32'h0);
        chk("rst_instr", ifid_instr_s, 32'h0);
        chk("rst_valid", {31'h0, ifid_valid_s}, 32'h0);
        chk("rst_scnt",  stall_cnt_s, 32'h0);
        chk("rst_fcnt",  flush_cnt_s, 32'h0);

        @(negedge clk_s);
        rst_n_s = 1'b1;
        start_s = 1'b1;
        tick();
        chk("run0_addr",  imem_addr_s, 32'h0);
        chk("run0_valid", {31'h0, ifid_valid_s}, 32'h0);
        tick();
        chk("run1_addr",  imem_addr_s, 32'h4);
        chk("run1_instr", ifid_instr_s, 32'h1);
        chk("run1_pc",    ifid_pc_s, 32'h4);
        chk("run1_valid", {31'h0, ifid_valid_s}, 32'h1);
        tick();
        chk("run2_addr",  imem_addr_s, 32'h8);
        chk("run2_instr", ifid_instr_s, 32'h2);

        stall_s = 1'b1;
        tick();
        chk("stl1_addr",  imem_addr_s, 32'h8);
        chk("stl1_instr", ifid_instr_s, 32'h2);
        tick();
        chk("stl2_addr",  imem_addr_s, 32'h8);
        chk("stl2_instr", ifid_instr_s, 32'h2);
        chk("stl2_valid", {31'h0, ifid_valid_s}, 32'h1);
        chk("stl2_scnt",  stall_cnt_s, cnt_exp(32'd2));
        stall_s = 1'b0;
        tick();
        chk("run3_addr",  imem_addr_s, 32'hC);
        chk("run3_instr", ifid_instr_s, 32'h3);

        flush_s  = 1'b1;
        target_s = 32'h40;
        tick();
        chk("fl_addr",  imem_addr_s, 32'h40);
        chk("fl_valid", {31'h0, ifid_valid_s}, 32'h0);
        chk("fl_instr", ifid_instr_s, 32'h0);
        chk("fl_fcnt",  flush_cnt_s, cnt_exp(32'd1));
        flush_s = 1'b0;
        tick();
        chk("br_addr",  imem_addr_s, 32'h44);
        chk("br_instr", ifid_instr_s, 32'h11);

        stall_s  = 1'b1;
        flush_s  = 1'b1;
        target_s = 32'h20;
        tick();
        chk("sf_addr",  imem_addr_s, 32'h20);
        chk("sf_valid", {31'h0, ifid_valid_s}, 32'h0);
        chk("sf_scnt",  stall_cnt_s, cnt_exp(32'd2));
        chk("sf_fcnt",  flush_cnt_s, cnt_exp(32'd2));
        stall_s  = 1'b0;
        target_s = 32'hFFFF_FFFC;
        tick();
        chk("top_addr", imem_addr_s, 32'hFFFF_FFFC);
        flush_s = 1'b0;
        tick();
        chk("wrap_addr",  imem_addr_s, 32'h0);
        chk("wrap_pc",    ifid_pc_s, 32'h0);
        chk("wrap_instr", ifid_instr_s, 32'h4000_0000);
        tick();
        chk("post_addr", imem_addr_s, 32'h4);

        stall_s = 1'b1;
        tick();
        chk("stl3_scnt", stall_cnt_s, cnt_exp(32'd3));
        #2;
        rst_n_s = 1'b0;
        #1;
        chk("arst_addr",  imem_addr_s, 32'h0);
        chk("arst_pc",    ifid_pc_s, 32'h0);
        chk("arst_instr", ifid_instr_s, 32'h0);
        chk("arst_valid", {31'h0, ifid_valid_s}, 32'h0);
        chk("arst_scnt",  stall_cnt_s, 32'h0);
        chk("arst_fcnt",  flush_cnt_s, 32'h0);

        @(negedge clk_s);
        stall_s = 1'b0;
        rst_n_s = 1'b1;
        tick();
        chk("rel0_addr", imem_addr_s, 32'h0);
        tick();
        chk("rel1_addr",  imem_addr_s, 32'h4);
        chk("rel1_instr", ifid_instr_s, 32'h1);

        start_s = 1'b0;
        tick();
        chk("stop_addr", imem_addr_s, 32'h8);
        flush_s  = 1'b1;
        stall_s  = 1'b1;
        target_s = 32'h80;
        tick();
        chk("idle_addr",  imem_addr_s, 32'h8);
        chk("idle_valid", {31'h0, ifid_valid_s}, 32'h0);
        chk("idle_fcnt",  flush_cnt_s, 32'h0);
        chk("idle_scnt",  stall_cnt_s, 32'h0);
        flush_s = 1'b0;

`ifdef IF_STAGE_PERF_CNT_EN
        start_s = 1'b1;
        tick();
        dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFF;
        tick();
        chk("sat_scnt", stall_cnt_s, 32'hFFFF_FFFF);
        stall_s = 1'b0;
`endif
        stall_s = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset and held while idle.
REQ-002 SHALL have parameter PC_STEP, default 4, byte increment applied to PC per sequential fetch.
REQ-003 SHALL have port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start_i, input, 1, run enable; 1 = fetch, 0 = idle.
REQ-006 SHALL have port stall_i, input, 1, load-use hold from the hazard unit; 1 = freeze PC and IF/ID.
REQ-007 SHALL have port flush_i, input, 1, taken-branch redirect; 1 = squash IF/ID and load branch_target_i.
REQ-008 SHALL have port branch_target_i, input, 32, redirect PC, sampled when flush_i = 1.
REQ-009 SHALL have port imem_addr_o, output, 32, instruction-memory byte address, equal to current PC.
REQ-010 SHALL have port imem_data_i, input, 32, combinational instruction word for imem_addr_o.
REQ-011 SHALL have port ifid_pc_o, output, 32, PC + PC_STEP of the instruction held in IF/ID.
REQ-012 SHALL have port ifid_instr_o, output, 32, instruction held in IF/ID; 32'h0 (NOP) when invalid.
REQ-013 SHALL have port ifid_valid_o, output, 1, 1 when IF/ID holds a real instruction.
REQ-014 SHALL have port stall_cnt_o, output, 32, count of stalled cycles.
REQ-015 SHALL have port flush_cnt_o, output, 32, count of flush cycles.

Function
REQ-016 SHALL implement FSM states IDLE and RUN; IDLE->RUN on a clock edge with start_i = 1; RUN->IDLE on an edge with start_i = 0.
REQ-017 SHALL, in IDLE, hold PC, load NOP with valid = 0 into IF/ID, and ignore stall_i and flush_i.
REQ-018 SHALL, in RUN with stall_i = 0 and flush_i = 0, load PC + PC_STEP into PC and {PC + PC_STEP, imem_data_i, 1} into IF/ID each cycle.
REQ-019 SHALL, in RUN with stall_i = 1 and flush_i = 0, hold PC and IF/ID unchanged.
REQ-020 SHALL, in RUN with flush_i = 1, load branch_target_i into PC and NOP with valid = 0 into IF/ID, regardless of stall_i (flush wins).
REQ-021 SHALL drive imem_addr_o combinationally from the PC register; the fetched word reaches IF/ID one cycle after its address is driven.
REQ-022 SHALL wrap PC addition modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
REQ-023 SHALL increment stall_cnt_o on each RUN cycle with stall_i = 1 and flush_i = 0, and flush_cnt_o on each RUN cycle with flush_i = 1.
REQ-024 SHALL saturate both counters at 32'hFFFF_FFFF.

Reset
REQ-025 SHALL, while rst_n_i = 0, force state IDLE, PC = RESET_PC, ifid_pc_o = 0, ifid_instr_o = 0, ifid_valid_o = 0, stall_cnt_o = 0, flush_cnt_o = 0, independently of clk_i.
REQ-026 SHALL, on reset asserted mid-stall or mid-flush, discard the pending operation; the first fetch after release with start_i = 1 is from RESET_PC.

Configuration
REQ-027 SHALL compile the stall/flush counters only when IF_STAGE_PERF_CNT_EN is defined.
REQ-028 SHALL, without IF_STAGE_PERF_CNT_EN, keep stall_cnt_o and flush_cnt_o as ports tied to constant 0, with no counter flops.

Structure
REQ-029 SHALL take RESET_PC default, PC_STEP default, NOP encoding (32'h0), and the IDLE/RUN state encoding from the shared CPU package.
REQ-030 SHALL instantiate one sub-module, if_perf_counter, containing one saturating 32-bit counter with enable; it is instantiated twice (stall, flush).

Verification
REQ-031 SHALL pass: reset, start_i = 1, imem word at addr k = k+1, no hazards -> imem_addr_o = 0,4,8,...; ifid_instr_o = 1,2,3 one cycle behind.
REQ-032 SHALL pass: stall_i = 1 for 2 cycles at PC = 8 -> PC stays 8, IF/ID holds the same instruction, stall_cnt_o = 2.
REQ-033 SHALL pass: flush_i = 1 with branch_target_i = 32'h40 -> next PC = 32'h40, ifid_valid_o = 0, ifid_instr_o = 0, flush_cnt_o = 1.
REQ-034 SHALL pass: stall_i = 1 and flush_i = 1 together, target 32'h20 -> PC = 32'h20, IF/ID flushed, stall_cnt_o unchanged, flush_cnt_o + 1.
REQ-035 SHALL pass: rst_n_i pulsed low mid-cycle during a stall -> all outputs 0 immediately, PC = RESET_PC, with no clock edge needed.
REQ-036 SHALL pass: PC forced to 32'hFFFF_FFFC, then one free fetch -> PC = 0; with the counter preset to 32'hFFFF_FFFF under IF_STAGE_PERF_CNT_EN, a further stall -> count stays 32'hFFFF_FFFF.
